// File: rtl/datapath.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : datapath                                               |
// | Description : Accumulator-machine datapath: PC, MAR, MDR, IR, ACC    |
// |               with a two-function ALU and an async-read memory port. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module datapath #(
  parameter int d_width    = 16,
  parameter int addr_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  muxPC,
  input  logic                  muxMAR,
  input  logic                  muxACC,
  input  logic                  loadPC,
  input  logic                  loadMAR,
  input  logic                  loadMDR,
  input  logic                  loadIR,
  input  logic                  loadACC,
  input  logic                  opALU,
  input  logic                  MemRW,
  output logic [addr_width-1:0] opcode,
  output logic                  zflag,
  output logic [addr_width-1:0] mem_addr,
  output logic [d_width-1:0]    mem_wdata,
  input  logic [d_width-1:0]    mem_rdata,
  output logic                  mem_we
);

  localparam logic [addr_width-1:0] c_pcOne = {{(addr_width-1){1'b0}}, 1'b1};

  logic [addr_width-1:0] r_pc;
  logic [addr_width-1:0] r_mar;
  logic [d_width-1:0]    r_mdr;
  logic [d_width-1:0]    r_ir;
  logic [d_width-1:0]    r_acc;

  logic [addr_width-1:0] w_irAddr;
  logic [addr_width-1:0] w_pcNext;
  logic [addr_width-1:0] w_marNext;
  logic [d_width-1:0]    w_alu;
  logic [d_width-1:0]    w_accNext;

  // All next-state values come from pre-edge register contents, so any mix
  // of load enables in one cycle behaves as independent parallel transfers.
  assign w_irAddr  = r_ir[addr_width-1:0];
  assign w_pcNext  = muxPC  ? w_irAddr : (r_pc + c_pcOne);
  assign w_marNext = muxMAR ? w_irAddr : r_pc;
  assign w_alu     = opALU  ? (r_acc + r_mdr) : (r_acc | r_mdr);
  assign w_accNext = muxACC ? r_mdr : w_alu;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= '0;
      r_mar <= '0;
      r_mdr <= '0;
      r_ir  <= '0;
      r_acc <= '0;
    end else begin
      if (loadPC)  r_pc  <= w_pcNext;
      if (loadMAR) r_mar <= w_marNext;
      if (loadMDR) r_mdr <= mem_rdata;
      if (loadIR)  r_ir  <= r_mdr;
      if (loadACC) r_acc <= w_accNext;
    end
  end

  // The opcode is the upper byte of the instruction word.
  assign opcode    = r_ir[d_width-1 -: addr_width];
  assign zflag     = (r_acc == '0);
  assign mem_addr  = r_mar;
  assign mem_wdata = r_acc;
  assign mem_we    = MemRW;

endmodule
`default_nettype wire

// File: tb/tb_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_datapath                                            |
// | Description : Table-driven bench for datapath with a 256x16 memory.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_datapath;

  // control word bit positions
  localparam logic [10:0] c_RST  = 11'h400;
  localparam logic [10:0] c_MPC  = 11'h200;
  localparam logic [10:0] c_MMAR = 11'h100;
  localparam logic [10:0] c_MACC = 11'h080;
  localparam logic [10:0] c_LPC  = 11'h040;
  localparam logic [10:0] c_LMAR = 11'h020;
  localparam logic [10:0] c_LMDR = 11'h010;
  localparam logic [10:0] c_LIR  = 11'h008;
  localparam logic [10:0] c_LACC = 11'h004;
  localparam logic [10:0] c_ALU  = 11'h002;
  localparam logic [10:0] c_WR   = 11'h001;

  typedef struct {
    logic [10:0] ctrl;
    logic        poke;
    logic [7:0]  pa;
    logic [15:0] pd;
    logic [7:0]  ePc;
    logic [7:0]  eMar;
    logic [15:0] eMdr;
    logic [15:0] eIr;
    logic [15:0] eAcc;
    logic        memChk;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, muxPC, muxMAR, muxACC;
  logic        loadPC, loadMAR, loadMDR, loadIR, loadACC, opALU, MemRW;
  logic [7:0]  opcode, mem_addr;
  logic        zflag, mem_we;
  logic [15:0] mem_wdata, mem_rdata;
  logic [15:0] mem [256];

  int nVec = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  datapath #(.d_width(16), .addr_width(8)) dut (
    .clk(clk), .rst(rst),
    .muxPC(muxPC), .muxMAR(muxMAR), .muxACC(muxACC),
    .loadPC(loadPC), .loadMAR(loadMAR), .loadMDR(loadMDR),
    .loadIR(loadIR), .loadACC(loadACC),
    .opALU(opALU), .MemRW(MemRW),
    .opcode(opcode), .zflag(zflag),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_we(mem_we)
  );

  task automatic drive(input logic [10:0] c);
    rst     = c[10];
    muxPC   = c[9];
    muxMAR  = c[8];
    muxACC  = c[7];
    loadPC  = c[6];
    loadMAR = c[5];
    loadMDR = c[4];
    loadIR  = c[3];
    loadACC = c[2];
    opALU   = c[1];
    MemRW   = c[0];
  endtask

  // One clock: optional memory poke, drive controls, edge, then memory commit.
  task automatic step(input logic [10:0] c, input logic poke,
                      input logic [7:0] pa, input logic [15:0] pd);
    logic        we;
    logic [7:0]  wa;
    logic [15:0] wd;
    if (poke) mem[pa] = pd;
    drive(c);
    #1;
    we = mem_we;
    wa = mem_addr;
    wd = mem_wdata;
    @(posedge clk);
    #1;
    if (we) mem[wa] = wd;
  endtask

  task automatic checkState(input string name, input logic [7:0] ePc,
                            input logic [7:0] eMar, input logic [15:0] eMdr,
                            input logic [15:0] eIr, input logic [15:0] eAcc);
    logic       eZ;
    logic [7:0] eOp;
    eZ  = (eAcc == 16'h0000);
    eOp = eIr[15:8];
    nVec++;
    if (dut.r_pc !== ePc || mem_addr !== eMar || dut.r_mdr !== eMdr ||
        dut.r_ir !== eIr || mem_wdata !== eAcc || zflag !== eZ ||
        opcode !== eOp || mem_we !== MemRW) begin
      nErr++;
      $display("FAIL %s: got pc=%h mar=%h mdr=%h ir=%h acc=%h z=%b op=%h we=%b; want pc=%h mar=%h mdr=%h ir=%h acc=%h z=%b op=%h we=%b",
               name, dut.r_pc, mem_addr, dut.r_mdr, dut.r_ir, mem_wdata, zflag,
               opcode, mem_we, ePc, eMar, eMdr, eIr, eAcc, eZ, eOp, MemRW);
    end
  endtask

  vec_t tbl[$];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0105;
    drive(11'h000);

    //             ctrl                          poke  pa     pd        pc     mar    mdr       ir        acc       mchk
    tbl.push_back('{c_RST,                        1'b0, 8'h00, 16'h0000, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{c_LPC | c_LMAR,               1'b0, 8'h00, 16'h0000, 8'h01, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{c_LMDR,                       1'b0, 8'h00, 16'h0000, 8'h01, 8'h00, 16'h0105, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{c_LIR,                        1'b0, 8'h00, 16'h0000, 8'h01, 8'h00, 16'h0105, 16'h0105, 16'h0000, 1'b0});
    tbl.push_back('{c_MMAR | c_LMAR,              1'b0, 8'h00, 16'h0000, 8'h01, 8'h05, 16'h0105, 16'h0105, 16'h0000, 1'b0});
    tbl.push_back('{c_LMDR,                       1'b1, 8'h05, 16'hFFFF, 8'h01, 8'h05, 16'hFFFF, 16'h0105, 16'h0000, 1'b0});
    tbl.push_back('{c_MACC | c_LACC,              1'b0, 8'h00, 16'h0000, 8'h01, 8'h05, 16'hFFFF, 16'h0105, 16'hFFFF, 1'b0});
    tbl.push_back('{c_LMDR,                       1'b1, 8'h05, 16'h0001, 8'h01, 8'h05, 16'h0001, 16'h0105, 16'hFFFF, 1'b0});
    tbl.push_back('{c_LACC | c_ALU,               1'b0, 8'h00, 16'h0000, 8'h01, 8'h05, 16'h0001, 16'h0105, 16'h0000, 1'b0});
    tbl.push_back('{c_LMDR,                       1'b1, 8'h05, 16'h00F0, 8'h01, 8'h05, 16'h00F0, 16'h0105, 16'h0000, 1'b0});
    tbl.push_back('{c_MACC | c_LACC,              1'b0, 8'h00, 16'h0000, 8'h01, 8'h05, 16'h00F0, 16'h0105, 16'h00F0, 1'b0});
    tbl.push_back('{c_LMDR,                       1'b1, 8'h05, 16'h0F0F, 8'h01, 8'h05, 16'h0F0F, 16'h0105, 16'h00F0, 1'b0});
    tbl.push_back('{c_LACC,                       1'b0, 8'h00, 16'h0000, 8'h01, 8'h05, 16'h0F0F, 16'h0105, 16'h0FFF, 1'b0});
    tbl.push_back('{c_MACC | c_LACC,              1'b0, 8'h00, 16'h0000, 8'h01, 8'h05, 16'h0F0F, 16'h0105, 16'h0F0F, 1'b0});
    tbl.push_back('{c_LMDR | c_LACC | c_ALU,      1'b1, 8'h05, 16'h0101, 8'h01, 8'h05, 16'h0101, 16'h0105, 16'h1E1E, 1'b0});
    tbl.push_back('{c_MPC | c_MMAR | c_MACC | c_ALU, 1'b0, 8'h00, 16'h0000, 8'h01, 8'h05, 16'h0101, 16'h0105, 16'h1E1E, 1'b0});
    tbl.push_back('{c_LMDR,                       1'b1, 8'h05, 16'h1234, 8'h01, 8'h05, 16'h1234, 16'h0105, 16'h1E1E, 1'b0});
    tbl.push_back('{c_MACC | c_LACC,              1'b0, 8'h00, 16'h0000, 8'h01, 8'h05, 16'h1234, 16'h0105, 16'h1234, 1'b0});
    tbl.push_back('{c_LMDR,                       1'b1, 8'h05, 16'h0020, 8'h01, 8'h05, 16'h0020, 16'h0105, 16'h1234, 1'b0});
    tbl.push_back('{c_LIR,                        1'b0, 8'h00, 16'h0000, 8'h01, 8'h05, 16'h0020, 16'h0020, 16'h1234, 1'b0});
    tbl.push_back('{c_MMAR | c_LMAR,              1'b0, 8'h00, 16'h0000, 8'h01, 8'h20, 16'h0020, 16'h0020, 16'h1234, 1'b0});
    tbl.push_back('{c_WR,                         1'b0, 8'h00, 16'h0000, 8'h01, 8'h20, 16'h0020, 16'h0020, 16'h1234, 1'b1});
    tbl.push_back('{c_LMDR,                       1'b1, 8'h20, 16'h05A7, 8'h01, 8'h20, 16'h05A7, 16'h0020, 16'h1234, 1'b0});
    tbl.push_back('{c_LIR,                        1'b0, 8'h00, 16'h0000, 8'h01, 8'h20, 16'h05A7, 16'h05A7, 16'h1234, 1'b0});
    tbl.push_back('{c_MPC | c_LPC,                1'b0, 8'h00, 16'h0000, 8'hA7, 8'h20, 16'h05A7, 16'h05A7, 16'h1234, 1'b0});
    tbl.push_back('{c_LMDR,                       1'b1, 8'h20, 16'h00FF, 8'hA7, 8'h20, 16'h00FF, 16'h05A7, 16'h1234, 1'b0});
    tbl.push_back('{c_LIR,                        1'b0, 8'h00, 16'h0000, 8'hA7, 8'h20, 16'h00FF, 16'h00FF, 16'h1234, 1'b0});
    tbl.push_back('{c_MPC | c_LPC,                1'b0, 8'h00, 16'h0000, 8'hFF, 8'h20, 16'h00FF, 16'h00FF, 16'h1234, 1'b0});
    tbl.push_back('{c_LPC | c_LMAR,               1'b0, 8'h00, 16'h0000, 8'h00, 8'hFF, 16'h00FF, 16'h00FF, 16'h1234, 1'b0});

    foreach (tbl[i]) begin
      step(tbl[i].ctrl, tbl[i].poke, tbl[i].pa, tbl[i].pd);
      checkState($sformatf("vec%0d", i), tbl[i].ePc, tbl[i].eMar,
                 tbl[i].eMdr, tbl[i].eIr, tbl[i].eAcc);
      if (tbl[i].memChk) begin
        nVec++;
        if (mem[tbl[i].eMar] !== tbl[i].eAcc) begin
          nErr++;
          $display("FAIL store vec%0d: mem[%h]=%h want %h", i, tbl[i].eMar,
                   mem[tbl[i].eMar], tbl[i].eAcc);
        end
      end
    end

    // mem_we follows MemRW with no clock edge involved
    drive(c_WR);
    #1;
    nVec++;
    if (mem_we !== 1'b1) begin
      nErr++;
      $display("FAIL we_comb_hi: mem_we=%b want 1", mem_we);
    end
    drive(11'h000);
    #1;
    nVec++;
    if (mem_we !== 1'b0) begin
      nErr++;
      $display("FAIL we_comb_lo: mem_we=%b want 0", mem_we);
    end

    // Reset in the ExecADD_2 cycle wins over every load enable
    step(c_LMDR, 1'b1, 8'hFF, 16'h0003);
    checkState("madd_ldmdr", 8'h00, 8'hFF, 16'h0003, 16'h00FF, 16'h1234);
    step(c_MACC | c_LACC, 1'b0, 8'h00, 16'h0000);
    checkState("madd_ldacc", 8'h00, 8'hFF, 16'h0003, 16'h00FF, 16'h0003);
    step(c_LMDR, 1'b0, 8'h00, 16'h0000);
    checkState("madd_exec1", 8'h00, 8'hFF, 16'h0003, 16'h00FF, 16'h0003);
    step(c_RST | c_LACC | c_ALU | c_LPC | c_LMAR | c_LMDR | c_LIR, 1'b0, 8'h00, 16'h0000);
    checkState("madd_rst", 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000);
    step(c_LACC | c_ALU, 1'b0, 8'h00, 16'h0000);
    checkState("post_rst_add", 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000);
    step(c_LMDR, 1'b0, 8'h00, 16'h0000);
    checkState("post_rst_mdr", 8'h00, 8'h00, 16'h0105, 16'h0000, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 The block SHALL take parameter d_width, default 16, as the data word, IR, MDR and ACC width.
REQ-002 The block SHALL take parameter addr_width, default 8, as the PC, MAR and memory address width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset; synchronous, active-high.
REQ-005 The block SHALL have ports muxPC, muxMAR and muxACC, input, 1 each, the source selects from the controller.
REQ-006 The block SHALL have ports loadPC, loadMAR, loadMDR, loadIR and loadACC, input, 1 each, the register load enables.
REQ-007 The block SHALL have port opALU, input, 1, the ALU select: 1 = add, 0 = bitwise OR.
REQ-008 The block SHALL have port MemRW, input, 1, the memory write request: 1 = write, 0 = read.
REQ-009 The block SHALL have port opcode, output, addr_width, equal to IR[15:8].
REQ-010 The block SHALL have port zflag, output, 1, high when ACC equals 0.
REQ-011 The block SHALL have ports mem_addr (output, addr_width), mem_wdata (output, d_width), mem_rdata (input, d_width) and mem_we (output, 1) to a 256x16 memory that reads asynchronously.

Function
REQ-012 Each register SHALL update only on a rising clk edge and only when its load enable is high; otherwise it holds.
REQ-013 PC update SHALL be: muxPC=0 -> PC+1, modulo 2^addr_width (8'hFF wraps to 8'h00); muxPC=1 -> IR[7:0].
REQ-014 MAR update SHALL be: muxMAR=0 -> PC (pre-increment value when loadPC is high in the same cycle); muxMAR=1 -> IR[7:0].
REQ-015 MDR update SHALL be MDR <= mem_rdata, sampled in the same cycle loadMDR is high.
REQ-016 IR update SHALL be IR <= MDR (MDR value before the edge).
REQ-017 ACC update SHALL be: muxACC=1 -> MDR; muxACC=0 -> ALU result.
REQ-018 The ALU result SHALL be combinational: opALU=1 -> ACC+MDR, modulo 2^16, carry discarded; opALU=0 -> ACC|MDR.
REQ-019 mem_addr SHALL equal MAR at all times.
REQ-020 mem_wdata SHALL equal ACC, and mem_we SHALL equal MemRW, combinationally.
REQ-021 Memory SHALL commit mem_wdata at mem_addr on the rising edge while mem_we=1; the datapath SHALL change no register because of a write.
REQ-022 zflag and opcode SHALL be combinational from the current ACC and IR, with zero latency after a register update.
REQ-023 Any combination of load enables asserted together SHALL update every enabled register in the same edge; all sources SHALL be pre-edge values.
REQ-024 Load enables with no defined meaning for a register (e.g. muxPC with loadPC=0) SHALL have no effect.
REQ-025 Per-instruction cycle behaviour under the controller sequence Fetch_1/2/3, Decode, Exec SHALL be:
- Fetch_1: MAR<=PC, PC<=PC+1
- Fetch_2: MDR<=mem[MAR]
- Fetch_3: IR<=MDR
- Decode: MAR<=IR[7:0]
- ADD/OR/LOAD: MDR<=mem[MAR], then ACC<=ACC+MDR, ACC|MDR or MDR
- STORE: mem[MAR]<=ACC
- JUMP: PC<=IR[7:0]

Reset
REQ-026 With rst high at a rising edge, PC, MAR, MDR, IR and ACC SHALL all become 0, overriding every load enable in that cycle.
REQ-027 After reset, outputs SHALL be opcode=0, zflag=1, mem_addr=0 and mem_wdata=0, with mem_we following MemRW.
REQ-028 Reset asserted mid-instruction (any cycle) SHALL take effect at the next edge, with no partial update; the first edge after rst is released SHALL behave per REQ-012.

Verification
REQ-029 The bench SHALL cover fetch: mem[0]=16'h0105, sequence Fetch_1/2/3, Decode -> PC=1, IR=16'h0105, opcode=8'h01, MAR=8'h05.
REQ-030 The bench SHALL cover ADD: ACC=16'hFFFF, mem[5]=16'h0001, ExecADD_1/2 -> ACC=16'h0000, zflag=1, carry discarded.
REQ-031 The bench SHALL cover OR and LOAD: ACC=16'h00F0, mem[5]=16'h0F0F, OR -> ACC=16'h0FFF; then LOAD mem[5] -> ACC=16'h0F0F, zflag=0.
REQ-032 The bench SHALL cover STORE and JUMP: ACC=16'h1234, MAR=8'h20, MemRW=1 for one cycle -> mem[8'h20]=16'h1234 with no register change; IR=16'h05A7, muxPC=1, loadPC=1 -> PC=8'hA7.
REQ-033 The bench SHALL cover PC wrap: PC=8'hFF, Fetch_1 -> PC=8'h00, MAR=8'hFF.
REQ-034 The bench SHALL cover reset mid-ADD: ACC=16'h0003, rst=1 in the ExecADD_2 cycle -> ACC=0, PC=0, zflag=1, no add performed.
